// File: rtl/writeback_load_unit_pkg.sv
// Shared definitions for the load/store data path: funct3 width encodings
// used by both the load extractor and the store-side formatter.
package writeback_load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Sign- or zero-extend a byte to a full word.
  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sign);
    return {{24{sign & b[7]}}, b};
  endfunction

  // Sign- or zero-extend a halfword to a full word.
  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sign);
    return {{16{sign & h[15]}}, h};
  endfunction

endpackage

// File: rtl/writeback_load_unit_lane.sv
// Combinational load formatter: picks the byte/halfword lane addressed by
// the low address bits, extends it, and reports misalignment.
module load_unit
  import writeback_load_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select from the byte offset; halfwords use only offset[1].
  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];
  end

  // Width/sign decode; unknown encodings pass the raw word and flag misaligned.
  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = ext8(byte_lane, 1'b1);
      F3_LBU: data = ext8(byte_lane, 1'b0);
      F3_LH: begin
        data       = ext16(half_lane, 1'b1);
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = ext16(half_lane, 1'b0);
        misaligned = offset[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = (offset != 2'd0);
      end
      default: begin
        data       = word;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_load_unit.sv
// Writeback stage: selects ALU result or formatted load data for the
// register file, keeps a one-cycle forwarding copy, misalignment flags and
// retire/load performance counters.
module writeback_load_unit
  import writeback_load_unit_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_from_memory,
  input  logic [2:0]  funct3_from_memory,
  input  logic [4:0]  rd_from_memory,
  input  logic        write_reg_from_memory,
  input  logic        select_from_memory,
  input  logic [31:0] out_from_memory_dcache,
  output logic [4:0]  rd_to_regfile,
  output logic [31:0] data_to_regfile,
  output logic        we_to_regfile,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        fwd_valid,
  output logic        misaligned_load,
  output logic        misaligned_sticky,
  output logic [31:0] retired_count,
  output logic [31:0] load_count
);

  // Counters wrap at 2**COUNT_W; the default gives the full 32-bit range.
  localparam logic [31:0] COUNT_MASK = 32'hFFFF_FFFF >> (32 - COUNT_W);

  logic [31:0] load_data;
  logic        load_misaligned;
  logic        misaligned_event;

  load_unit u_load_unit (
    .word       (out_from_memory_dcache),
    .funct3     (funct3_from_memory),
    .offset     (result_from_memory[1:0]),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  // Zero-latency register-file write port, independent of reset.
  always_comb begin
    rd_to_regfile   = rd_from_memory;
    data_to_regfile = select_from_memory ? load_data : result_from_memory;
    we_to_regfile   = write_reg_from_memory && (rd_from_memory != '0);
  end

  assign misaligned_event = select_from_memory && write_reg_from_memory && load_misaligned;

  // Forwarding copy; rd/data hold while no write is requested so idle cycles
  // only drop fwd_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_rd    <= '0;
      fwd_data  <= '0;
      fwd_valid <= 1'b0;
    end else begin
      fwd_valid <= we_to_regfile;
      if (write_reg_from_memory) begin
        fwd_rd   <= rd_to_regfile;
        fwd_data <= data_to_regfile;
      end
    end
  end

  // Misalignment pulse and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_load   <= 1'b0;
      misaligned_sticky <= 1'b0;
    end else begin
      misaligned_load <= misaligned_event;
      if (misaligned_event) misaligned_sticky <= 1'b1;
    end
  end

  // Retire and load performance counters, wrapping silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count <= '0;
      load_count    <= '0;
    end else begin
      if (we_to_regfile) retired_count <= (retired_count + 32'd1) & COUNT_MASK;
      if (we_to_regfile && select_from_memory) load_count <= (load_count + 32'd1) & COUNT_MASK;
    end
  end

endmodule

// File: tb/tb_writeback_load_unit.sv
// Bench for writeback_load_unit: directed vector table, randomized traffic
// against a behavioural model, reset-in-flight and counter wrap sequences.
module tb_writeback_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_from_memory;
  logic [2:0]  funct3_from_memory;
  logic [4:0]  rd_from_memory;
  logic        write_reg_from_memory;
  logic        select_from_memory;
  logic [31:0] out_from_memory_dcache;

  logic [4:0]  rd_to_regfile, fwd_rd;
  logic [31:0] data_to_regfile, fwd_data, retired_count, load_count;
  logic        we_to_regfile, fwd_valid, misaligned_load, misaligned_sticky;

  logic [4:0]  s_rd_to_regfile, s_fwd_rd;
  logic [31:0] s_data_to_regfile, s_fwd_data, s_retired_count, s_load_count;
  logic        s_we_to_regfile, s_fwd_valid, s_misaligned_load, s_misaligned_sticky;

  always #5 clk = ~clk;

  writeback_load_unit dut (
    .clk(clk), .rst(rst),
    .result_from_memory(result_from_memory), .funct3_from_memory(funct3_from_memory),
    .rd_from_memory(rd_from_memory), .write_reg_from_memory(write_reg_from_memory),
    .select_from_memory(select_from_memory), .out_from_memory_dcache(out_from_memory_dcache),
    .rd_to_regfile(rd_to_regfile), .data_to_regfile(data_to_regfile), .we_to_regfile(we_to_regfile),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .misaligned_load(misaligned_load), .misaligned_sticky(misaligned_sticky),
    .retired_count(retired_count), .load_count(load_count)
  );

  // Narrow-counter instance so the wrap boundary is reachable in simulation.
  writeback_load_unit #(.COUNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .result_from_memory(result_from_memory), .funct3_from_memory(funct3_from_memory),
    .rd_from_memory(rd_from_memory), .write_reg_from_memory(write_reg_from_memory),
    .select_from_memory(select_from_memory), .out_from_memory_dcache(out_from_memory_dcache),
    .rd_to_regfile(s_rd_to_regfile), .data_to_regfile(s_data_to_regfile), .we_to_regfile(s_we_to_regfile),
    .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data), .fwd_valid(s_fwd_valid),
    .misaligned_load(s_misaligned_load), .misaligned_sticky(s_misaligned_sticky),
    .retired_count(s_retired_count), .load_count(s_load_count)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  logic [31:0] m_retired, m_load, m_fwd_data;
  logic [4:0]  m_fwd_rd;
  logic        m_fwd_valid, m_pulse, m_sticky;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] word;
    logic        sel;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (32'(off) * 8)) & 32'hFF;
    h = (w >> (32'(off / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (off % 2) != 0;
      3'd2:       return off != 0;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_retired = 0; m_load = 0; m_fwd_data = 0; m_fwd_rd = 0;
    m_fwd_valid = 0; m_pulse = 0; m_sticky = 0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] res, input logic [31:0] word,
                       input logic sel, input logic wr, input logic [4:0] rd);
    funct3_from_memory     = f3;
    result_from_memory     = res;
    out_from_memory_dcache = word;
    select_from_memory     = sel;
    write_reg_from_memory  = wr;
    rd_from_memory         = rd;
  endtask

  // One clock of traffic with the currently driven inputs.
  task automatic run_cycle();
    logic [31:0] e_data;
    logic        e_we;
    #1;
    e_data = select_from_memory ? ref_load(out_from_memory_dcache, funct3_from_memory,
                                           result_from_memory[1:0]) : result_from_memory;
    e_we   = write_reg_from_memory && (rd_from_memory != 0);
    chk("rd_to_regfile", 32'(rd_to_regfile), 32'(rd_from_memory));
    chk("data_to_regfile", data_to_regfile, e_data);
    chk("we_to_regfile", 32'(we_to_regfile), 32'(e_we));
    @(posedge clk);
    m_fwd_valid = e_we;
    if (write_reg_from_memory) begin
      m_fwd_rd   = rd_from_memory;
      m_fwd_data = e_data;
    end
    if (e_we) m_retired = m_retired + 1;
    if (e_we && select_from_memory) m_load = m_load + 1;
    m_pulse = select_from_memory && write_reg_from_memory &&
              ref_mis(funct3_from_memory, result_from_memory[1:0]);
    if (m_pulse) m_sticky = 1'b1;
    #1;
    chk("fwd_rd", 32'(fwd_rd), 32'(m_fwd_rd));
    chk("fwd_data", fwd_data, m_fwd_data);
    chk("fwd_valid", 32'(fwd_valid), 32'(m_fwd_valid));
    chk("misaligned_load", 32'(misaligned_load), 32'(m_pulse));
    chk("misaligned_sticky", 32'(misaligned_sticky), 32'(m_sticky));
    chk("retired_count", retired_count, m_retired);
    chk("load_count", load_count, m_load);
    chk("small_retired_count", s_retired_count, m_retired % 16);
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_fwd_rd"}, 32'(fwd_rd), 32'd0);
    chk({tag, "_fwd_data"}, fwd_data, 32'd0);
    chk({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({tag, "_misaligned_load"}, 32'(misaligned_load), 32'd0);
    chk({tag, "_misaligned_sticky"}, 32'(misaligned_sticky), 32'd0);
    chk({tag, "_retired_count"}, retired_count, 32'd0);
    chk({tag, "_load_count"}, load_count, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_1003, 32'h8011_2233, 1'b1, 1'b1, 5'd5,  32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[1]  = '{3'b101, 32'h0000_2002, 32'hBEEF_1234, 1'b1, 1'b1, 5'd6,  32'h0000_BEEF, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 32'h0000_2002, 32'hBEEF_1234, 1'b1, 1'b1, 5'd6,  32'hFFFF_BEEF, 1'b1, 1'b0};
    vecs[3]  = '{3'b010, 32'h0000_3001, 32'hCAFE_F00D, 1'b1, 1'b1, 5'd7,  32'hCAFE_F00D, 1'b1, 1'b1};
    vecs[4]  = '{3'b010, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd0,  32'h0000_1234, 1'b0, 1'b0};
    vecs[5]  = '{3'b100, 32'h0000_4001, 32'h8011_2233, 1'b1, 1'b1, 5'd8,  32'h0000_0022, 1'b1, 1'b0};
    vecs[6]  = '{3'b000, 32'h0000_4000, 32'h0000_00FF, 1'b1, 1'b1, 5'd8,  32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7]  = '{3'b001, 32'h0000_5001, 32'h1234_8765, 1'b1, 1'b1, 5'd10, 32'hFFFF_8765, 1'b1, 1'b1};
    vecs[8]  = '{3'b011, 32'h0000_6000, 32'h55AA_55AA, 1'b1, 1'b1, 5'd11, 32'h55AA_55AA, 1'b1, 1'b1};
    vecs[9]  = '{3'b110, 32'h0000_0077, 32'h1111_1111, 1'b0, 1'b1, 5'd9,  32'h0000_0077, 1'b1, 1'b0};
    vecs[10] = '{3'b010, 32'h0000_7000, 32'h0BAD_F00D, 1'b1, 1'b1, 5'd31, 32'h0BAD_F00D, 1'b1, 1'b0};
    vecs[11] = '{3'b010, 32'h0000_7001, 32'h1111_2222, 1'b1, 1'b0, 5'd4,  32'h1111_2222, 1'b0, 1'b0};

    rst = 1'b1;
    drive(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    model_reset();
    #1;
    chk_regs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].f3, vecs[i].res, vecs[i].word, vecs[i].sel, vecs[i].wr, vecs[i].rd);
      #1;
      chk($sformatf("vec%0d_data", i), data_to_regfile, vecs[i].exp_data);
      chk($sformatf("vec%0d_we", i), 32'(we_to_regfile), 32'(vecs[i].exp_we));
      run_cycle();
      chk($sformatf("vec%0d_mis", i), 32'(misaligned_load), 32'(vecs[i].exp_mis));
      if (i == 0) begin
        chk("vec0_fwd_rd", 32'(fwd_rd), 32'd5);
        chk("vec0_fwd_data", fwd_data, 32'hFFFF_FF80);
        chk("vec0_load_count", load_count, 32'd1);
      end
    end
    chk("sticky_after_table", 32'(misaligned_sticky), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(0, 7)), $urandom, $urandom, ($urandom % 4) != 0,
            ($urandom % 8) != 0, (($urandom % 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      run_cycle();
    end

    // Reset asserted mid-cycle with a write in flight
    drive(3'b010, 32'h0000_0100, 32'hA5A5_5A5A, 1'b1, 1'b1, 5'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_regs_zero("async_rst");
    chk("rst_comb_data", data_to_regfile, 32'hA5A5_5A5A);
    chk("rst_comb_we", 32'(we_to_regfile), 32'd1);
    @(posedge clk);
    #1;
    chk_regs_zero("inflight");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_cycle();
    chk("resume_retired", retired_count, 32'd1);

    // Counter wrap on the narrow instance
    for (int i = 0; i < 14; i++) begin
      drive(3'b010, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 5'd1);
      run_cycle();
    end
    chk("small_at_max", s_retired_count, 32'h0000_000F);
    run_cycle();
    chk("small_wrapped", s_retired_count, 32'd0);
    chk("main_after_wrap", retired_count, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
